// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, requester ID
// and the round-robin pick between the two requesters.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic req_id_t;

  // On a tie the requester that was not granted last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input req_id_t last_id);
    logic [1:0] g;
    g = 2'b00;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last_id ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of {A, Q, Q-1}.
module booth_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH:0]   m_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             qm1_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             qm1_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a_i;
    case ({q_i[0], qm1_i})
      2'b01:   sum = a_i + m_i;
      2'b10:   sum = a_i - m_i;
      default: sum = a_i;
    endcase
    a_o   = {sum[WIDTH], sum[WIDTH:1]};
    q_o   = {sum[0], q_i[WIDTH-1:1]};
    qm1_o = q_i[0];
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Two-requester round-robin front end sharing one sequential Booth datapath;
// one Booth step per clock, result tagged with the requester ID.
module booth_mult_arbiter
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic [1:0]           gnt,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d, m_q, m_d, a_n;
  logic [WIDTH-1:0]     q_q, q_d, q_n;
  logic                 qm1_q, qm1_d, qm1_n;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  req_id_t              id_q, id_d, last_id_q, last_id_d, sel_id;
  logic                 busy_q, busy_d, done_q, done_d, done_id_q, done_id_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 accept;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i   (a_q),
    .m_i   (m_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .a_o   (a_n),
    .q_o   (q_n),
    .qm1_o (qm1_n)
  );

  always_comb begin
    gnt = (state_q == ST_IDLE) ? rr_pick({req1, req0}, last_id_q) : 2'b00;
  end

  assign sel_id = gnt[1];
  assign accept = |(gnt & {req1, req0});

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d       = '0;
          m_d       = sel_id ? {a1[WIDTH-1], a1} : {a0[WIDTH-1], a0};
          q_d       = sel_id ? b1 : b0;
          qm1_d     = 1'b0;
          cnt_d     = CNT_W'(WIDTH - 1);
          id_d      = sel_id;
          last_id_d = sel_id;
          busy_d    = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d   = a_n;
        q_d   = q_n;
        qm1_d = qm1_n;
        if (cnt_q == '0) begin
          // Result is taken straight from the final step so it lands with done.
          product_d = {a_n[WIDTH-1:0], q_n};
          done_d    = 1'b1;
          done_id_d = id_q;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter at WIDTH=4 with hand-computed products.
module tb_booth_mult_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] gnt;
  logic       busy, done, done_id;
  logic [7:0] product;

  int checks = 0;
  int errors = 0;

  booth_mult_arbiter #(.WIDTH(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .product (product)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called in the first RUN cycle; done is expected exp_n cycles later.
  task automatic wait_done(input logic [7:0] exp_p, input logic exp_id, input int exp_n, input string tag);
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 16'(n), 16'(exp_n));
    chk({tag, "_prod"}, {8'h0, product}, {8'h0, exp_p});
    chk({tag, "_id"}, {15'h0, done_id}, {15'h0, exp_id});
    tick();
  endtask

  task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp_p, input string tag);
    if (id == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
    else         begin a1 = a; b1 = b; req1 = 1'b1; end
    #1;
    chk({tag, "_gnt"}, {14'h0, gnt}, (id == 0) ? 16'h1 : 16'h2);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    wait_done(exp_p, id[0], 4, tag);
  endtask

  initial begin
    int gid[4], gcyc[4], did[4];
    logic [7:0] dprod[4];
    int ng, nd, cyc;
    reset = 1'b1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", {15'h0, busy}, 16'h0);
    chk("rst_done", {15'h0, done}, 16'h0);
    chk("rst_done_id", {15'h0, done_id}, 16'h0);
    chk("rst_product", {8'h0, product}, 16'h0);
    chk("rst_gnt", {14'h0, gnt}, 16'h0);

    // -3 x 5 = -15 with full cycle-by-cycle busy/done profile
    a0 = 4'hD; b0 = 4'h5; req0 = 1'b1;
    #1;
    chk("single_gnt", {14'h0, gnt}, 16'h1);
    tick();
    req0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("single_busy%0d", k), {15'h0, busy}, 16'h1);
      chk($sformatf("single_done%0d", k), {15'h0, done}, (k == 5) ? 16'h1 : 16'h0);
      if (k < 5) tick();
    end
    chk("single_prod", {8'h0, product}, 16'h00F1);
    chk("single_id", {15'h0, done_id}, 16'h0);
    tick();
    chk("single_busy_off", {15'h0, busy}, 16'h0);
    chk("single_done_off", {15'h0, done}, 16'h0);
    chk("single_hold", {8'h0, product}, 16'h00F1);

    run_op(1, 4'h8, 4'h8, 8'h40, "c_m8m8");
    run_op(1, 4'h7, 4'h8, 8'hC8, "c_7m8");
    run_op(1, 4'h0, 4'h8, 8'h00, "c_0m8");
    run_op(1, 4'h8, 4'h7, 8'hC8, "c_m87");

    // Contention from a fresh reset: 3x2=6 vs -2x5=-10
    reset = 1'b1; tick(); reset = 1'b0;
    a0 = 4'h3; b0 = 4'h2; a1 = 4'hE; b1 = 4'h5;
    req0 = 1'b1; req1 = 1'b1;
    ng = 0; nd = 0; cyc = 0;
    #1;
    while (nd < 4 && cyc < 60) begin
      if (gnt != 2'b00 && ng < 4) begin
        gid[ng] = (gnt == 2'b10) ? 1 : 0;
        gcyc[ng] = cyc;
        ng++;
      end
      if (done && nd < 4) begin
        did[nd] = int'(done_id);
        dprod[nd] = product;
        nd++;
      end
      tick();
      cyc++;
      if (ng >= 4) begin req0 = 1'b0; req1 = 1'b0; end
    end
    chk("cont_ngrants", 16'(ng), 16'd4);
    chk("cont_ndones", 16'(nd), 16'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cont_gid%0d", i), 16'(gid[i]), 16'(i % 2));
      chk($sformatf("cont_did%0d", i), 16'(did[i]), 16'(i % 2));
      chk($sformatf("cont_prod%0d", i), {8'h0, dprod[i]}, (i % 2) ? 16'h00F6 : 16'h0006);
      if (i > 0) chk($sformatf("cont_space%0d", i), 16'(gcyc[i] - gcyc[i-1]), 16'd6);
    end
    repeat (8) tick();

    // req1 raised mid-operation: 1 x -1 then -5 x 3
    a0 = 4'h1; b0 = 4'hF; req0 = 1'b1;
    #1;
    chk("mid_gnt0", {14'h0, gnt}, 16'h1);
    tick();
    req0 = 1'b0;
    tick();
    a1 = 4'hB; b1 = 4'h3; req1 = 1'b1;
    #1;
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("mid_nognt%0d", k), {14'h0, gnt}, 16'h0);
      if (k < 5) tick();
    end
    chk("mid_done", {15'h0, done}, 16'h1);
    chk("mid_prod0", {8'h0, product}, 16'h00FF);
    chk("mid_id0", {15'h0, done_id}, 16'h0);
    tick();
    chk("mid_gnt1", {14'h0, gnt}, 16'h2);
    tick();
    req1 = 1'b0;
    wait_done(8'hF1, 1'b1, 4, "mid_op1");

    // Reset on the second RUN cycle aborts the operation
    a0 = 4'h5; b0 = 4'h5; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {15'h0, busy}, 16'h0);
    chk("abort_prod", {8'h0, product}, 16'h0);
    chk("abort_done", {15'h0, done}, 16'h0);
    begin
      int seen = 0;
      repeat (6) begin
        tick();
        if (done) seen++;
      end
      chk("abort_nodone", 16'(seen), 16'h0);
    end
    run_op(0, 4'h2, 4'h3, 8'h06, "after_abort");

    // Exhaustive signed sweep on alternating requesters
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      logic signed [3:0] sa, sb;
      int p;
      logic [31:0] pv;
      iv = 8'(i);
      sa = iv[7:4];
      sb = iv[3:0];
      p = int'(sa) * int'(sb);
      pv = p;
      run_op(i % 2, iv[7:4], iv[3:0], pv[7:0], $sformatf("sweep_%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Sequential radix-2 Booth multiplier controller that shares one Booth step datapath between two requesters. Round-robin arbitration on a req/gnt handshake, operand capture, one Booth iteration per clock for WIDTH clocks, then a one-cycle `done` pulse with a signed 2·WIDTH-bit product tagged with the requester ID. Sits between the requesting units and the multiply datapath; replaces the unrolled four-stage Booth chain when area matters more than latency.

## Interface
- `WIDTH`, default 4: operand width. Signed two's complement. Must be ≥ 2.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req0`  in  1  requester 0 operation request. Held until granted.
- `a0`  in  WIDTH  requester 0 multiplicand, signed.
- `b0`  in  WIDTH  requester 0 multiplier, signed.
- `req1`, `a1`, `b1`: same as above, for requester 1.
- `gnt`  out  2  one-hot grant. Combinational, asserted only in IDLE.
- `busy`  out  1  high from the cycle after capture through the DONE cycle.
- `done`  out  1  one-cycle pulse; `product` and `done_id` valid.
- `done_id`  out  1  requester whose result is on `product`.
- `product`  out  2·WIDTH  signed product. Holds its last value until the next `done`.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - If exactly one `req` is high, grant it.
  - If both are high, grant the requester not granted last (`last_id` register).
  - An operation is accepted at the edge where `req[i] & gnt[i]`.
  - On acceptance: A←0 (WIDTH+1 bits), M←sign-extended a_i (WIDTH+1 bits), Q←b_i, Q₋₁←0, cnt←WIDTH−1, id←i, `last_id`←i. Go to RUN.
- **RUN** (one Booth step per cycle, implemented by `booth_step`):
  - {Q[0],Q₋₁}=01 → A←A+M.
  - {Q[0],Q₋₁}=10 → A←A−M.
  - 00 or 11 → A unchanged.
  - Then arithmetic right shift of {A,Q,Q₋₁} by one.
  - When cnt=0, go to DONE; otherwise cnt←cnt−1.
- **DONE**
  - `done`=1, `done_id`=id, `product`=low 2·WIDTH bits of {A,Q}, registered on entry.
  - Always returns to IDLE next cycle. No grant is issued in DONE.
- Width rule: A is WIDTH+1 bits so that −M does not overflow when a=−2^(WIDTH−1). The result is exact for all operand pairs.
- A requester that drops `req` before it is granted is ignored; no result is produced for it.
- `req` during RUN or DONE is neither granted nor lost; it is serviced in a later IDLE.

## Timing
- Reset values: state=IDLE, `gnt`=0 except the combinational IDLE grant, `busy`=0, `done`=0, `done_id`=0, `product`=0, `last_id`=1 (requester 0 wins the first tie).
- Capture at edge E. Cycles E+1…E+WIDTH are RUN. Cycle E+WIDTH+1 is DONE (`done` high).
- `busy` is high for cycles E+1…E+WIDTH+1.
- Earliest next grant is in cycle E+WIDTH+2. Back-to-back throughput is one operation per WIDTH+2 cycles.
- `reset` asserted in RUN or DONE aborts the operation: no `done`, and all outputs return to reset values on the next edge.
- Simultaneous `reset` and capture: `reset` wins and nothing is accepted.

## Structure
- Package `booth_pkg`:
  - state enum (IDLE, RUN, DONE)
  - default WIDTH constant
  - requester ID type
- Sub-module `booth_step`: purely combinational. Inputs A, M, Q, Q₋₁; outputs the next A, Q, Q₋₁. Instantiated once.
- The top module holds the FSM, counter, round-robin pointer and operand/result registers.

## Test plan
- Single request, WIDTH=4: req0 with a0=−3, b0=5 → `gnt`=01 in the same cycle; `done` 5 cycles after the capture edge; `product`=8'hF1, `done_id`=0; `busy` high for 5 cycles.
- Corner operands on requester 1: a1=−8, b1=−8 → `product`=8'h40. Then 7×−8 → 8'hC8. Then 0×−8 → 8'h00. Then −8×7 → 8'hC8.
- Contention: req0 and req1 both held continuously.
  - Grants alternate 0,1,0,1 (first tie goes to 0).
  - `done_id` sequence is 0,1,0,1.
  - Grants are spaced exactly 6 cycles apart.
- Request during RUN: req1 raised mid-operation → no grant until IDLE; serviced immediately after DONE with the correct product.
- Reset in RUN: assert `reset` on the 2nd RUN cycle → no `done`; `busy`=0 and `product`=0 on the next edge; a fresh req0 (2×3) then yields 8'h06.
- Exhaustive sweep: all 256 signed operand pairs on alternating requesters, each result equal to the signed reference product.
